// File: rtl/decode_stage_if.sv
// Signal bundle between IF/ID, writeback and the decode stage's ID/EX outputs.
// The slave modport is the decode stage; master is the surrounding pipeline.
interface decode_stage_if;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;

    logic [DATA_W-1:0] instruction;
    logic [DATA_W-1:0] pc_plus4;
    logic              if_valid;
    logic              flush;
    logic              wb_reg_write;
    logic [REG_W-1:0]  wb_write_reg;
    logic [DATA_W-1:0] wb_write_data;

    logic              stall;
    logic              id_valid;
    logic [DATA_W-1:0] read_data_1;
    logic [DATA_W-1:0] read_data_2;
    logic [DATA_W-1:0] extended_offset;
    logic [DATA_W-1:0] old_address;
    logic [1:0]        ALU_op;
    logic              ALU_src;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              branch;
    logic [REG_W-1:0]  write_reg;
    logic              illegal;

    modport master (
        output instruction, pc_plus4, if_valid, flush,
               wb_reg_write, wb_write_reg, wb_write_data,
        input  stall, id_valid, read_data_1, read_data_2, extended_offset,
               old_address, ALU_op, ALU_src, reg_write, mem_read, mem_write,
               mem_to_reg, branch, write_reg, illegal
    );

    modport slave (
        input  instruction, pc_plus4, if_valid, flush,
               wb_reg_write, wb_write_reg, wb_write_data,
        output stall, id_valid, read_data_1, read_data_2, extended_offset,
               old_address, ALU_op, ALU_src, reg_write, mem_read, mem_write,
               mem_to_reg, branch, write_reg, illegal
    );
endinterface

// File: rtl/decode_stage.sv
// MIPS instruction-decode stage: register file, control decode, ID/EX register.
// Define DECODE_HAZARD_EN to enable load-use stall and bubble insertion.
module decode_stage (
    input  logic           clk,
    input  logic           rst,
    decode_stage_if.slave  bus
);
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned NUM_REGS = 32;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] ext;
        logic [DATA_W-1:0] old_addr;
        logic [1:0]        alu_op;
        logic              alu_src;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        logic              branch;
        logic [REG_W-1:0]  write_reg;
    } idex_t;

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    idex_t             r_idex;
    idex_t             w_idex_nxt;
    idex_t             w_dec;
    logic              r_illegal;
    logic              w_illegal_nxt;
    logic [5:0]        w_opcode;
    logic [REG_W-1:0]  w_rs;
    logic [REG_W-1:0]  w_rt;
    logic [REG_W-1:0]  w_rd;
    logic [DATA_W-1:0] w_rs_data;
    logic [DATA_W-1:0] w_rt_data;
    logic              w_known;
    logic              w_stall;

    assign w_opcode = bus.instruction[31:26];
    assign w_rs     = bus.instruction[25:21];
    assign w_rt     = bus.instruction[20:16];
    assign w_rd     = bus.instruction[15:11];

    // Register reads with same-cycle writeback bypass; $0 is hardwired zero.
    always_comb begin
        w_rs_data = r_regs[w_rs];
        w_rt_data = r_regs[w_rt];
        if (w_rs == '0)
            w_rs_data = '0;
        else if (bus.wb_reg_write && (bus.wb_write_reg == w_rs))
            w_rs_data = bus.wb_write_data;
        if (w_rt == '0)
            w_rt_data = '0;
        else if (bus.wb_reg_write && (bus.wb_write_reg == w_rt))
            w_rt_data = bus.wb_write_data;
    end

    always_comb begin
        w_dec           = '0;
        w_known         = 1'b1;
        w_dec.valid     = 1'b1;
        w_dec.rd1       = w_rs_data;
        w_dec.rd2       = w_rt_data;
        w_dec.ext       = {{16{bus.instruction[15]}}, bus.instruction[15:0]};
        w_dec.old_addr  = bus.pc_plus4;
        w_dec.write_reg = w_rt;
        case (w_opcode)
            OP_RTYPE: begin
                w_dec.alu_op    = 2'b10;
                w_dec.reg_write = 1'b1;
                w_dec.write_reg = w_rd;
            end
            OP_LW: begin
                w_dec.alu_src    = 1'b1;
                w_dec.mem_read   = 1'b1;
                w_dec.mem_to_reg = 1'b1;
                w_dec.reg_write  = 1'b1;
            end
            OP_SW: begin
                w_dec.alu_src   = 1'b1;
                w_dec.mem_write = 1'b1;
            end
            OP_BEQ: begin
                w_dec.alu_op = 2'b01;
                w_dec.branch = 1'b1;
            end
            OP_ADDI: begin
                w_dec.alu_src   = 1'b1;
                w_dec.reg_write = 1'b1;
            end
            default: w_known = 1'b0;
        endcase
    end

`ifdef DECODE_HAZARD_EN
    logic w_uses_rt;
    assign w_uses_rt = (w_opcode == OP_RTYPE) || (w_opcode == OP_SW) || (w_opcode == OP_BEQ);
    // Load in ID/EX whose destination is a source of the instruction in decode.
    assign w_stall = !rst && !bus.flush && bus.if_valid
                   && r_idex.valid && r_idex.mem_read && (r_idex.write_reg != '0)
                   && ((r_idex.write_reg == w_rs) || ((r_idex.write_reg == w_rt) && w_uses_rt));
`else
    assign w_stall = 1'b0;
`endif

    always_comb begin
        w_idex_nxt    = '0;
        w_illegal_nxt = r_illegal;
        if (bus.if_valid && !bus.flush && !w_known)
            w_illegal_nxt = 1'b1;
        if (bus.if_valid && !bus.flush && !w_stall && w_known)
            w_idex_nxt = w_dec;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idex    <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_idex    <= w_idex_nxt;
            r_illegal <= w_illegal_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++)
                r_regs[i] <= '0;
        end else if (bus.wb_reg_write && (bus.wb_write_reg != '0)) begin
            r_regs[bus.wb_write_reg] <= bus.wb_write_data;
        end
    end

    assign bus.stall           = w_stall;
    assign bus.id_valid        = r_idex.valid;
    assign bus.read_data_1     = r_idex.rd1;
    assign bus.read_data_2     = r_idex.rd2;
    assign bus.extended_offset = r_idex.ext;
    assign bus.old_address     = r_idex.old_addr;
    assign bus.ALU_op          = r_idex.alu_op;
    assign bus.ALU_src         = r_idex.alu_src;
    assign bus.reg_write       = r_idex.reg_write;
    assign bus.mem_read        = r_idex.mem_read;
    assign bus.mem_write       = r_idex.mem_write;
    assign bus.mem_to_reg      = r_idex.mem_to_reg;
    assign bus.branch          = r_idex.branch;
    assign bus.write_reg       = r_idex.write_reg;
    assign bus.illegal         = r_illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized
// traffic against an instruction-level reference model.
module tb_decode_stage;
`ifdef DECODE_HAZARD_EN
    localparam bit HAZ = 1'b1;
`else
    localparam bit HAZ = 1'b0;
`endif

    typedef struct packed {
        logic        valid;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] ext;
        logic [31:0] old;
        logic [1:0]  alu_op;
        logic        alu_src;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        m2r;
        logic        br;
        logic [4:0]  wreg;
        logic        illegal;
    } out_t;

    logic clk;
    logic rst;
    decode_stage_if bus();

    decode_stage dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    checks;
    int    passes;
    logic [31:0] m_regs [32];
    out_t  m_out;
    logic  exp_stall;
    logic  got_stall;

    function automatic out_t dut_out();
        out_t o;
        o.valid   = bus.id_valid;
        o.rd1     = bus.read_data_1;
        o.rd2     = bus.read_data_2;
        o.ext     = bus.extended_offset;
        o.old     = bus.old_address;
        o.alu_op  = bus.ALU_op;
        o.alu_src = bus.ALU_src;
        o.rw      = bus.reg_write;
        o.mr      = bus.mem_read;
        o.mw      = bus.mem_write;
        o.m2r     = bus.mem_to_reg;
        o.br      = bus.branch;
        o.wreg    = bus.write_reg;
        o.illegal = bus.illegal;
        return o;
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] idx, input logic we,
                                             input logic [4:0] wr, input logic [31:0] wd);
        if (idx == 5'd0) return 32'd0;
        if (we && wr == idx) return wd;
        return m_regs[idx];
    endfunction

    // Drive one cycle, sample stall before the edge, advance the model across it.
    task automatic cycle(input logic r, input logic [31:0] ins, input logic [31:0] pc,
                         input logic ifv, input logic fl, input logic we,
                         input logic [4:0] wr, input logic [31:0] wd);
        out_t nxt;
        logic [5:0] op;
        logic [4:0] rs, rt;
        logic known, uses_rt;
        @(negedge clk);
        rst = r;
        bus.instruction = ins; bus.pc_plus4 = pc; bus.if_valid = ifv; bus.flush = fl;
        bus.wb_reg_write = we; bus.wb_write_reg = wr; bus.wb_write_data = wd;
        #1;
        op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16];
        known   = op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h08};
        uses_rt = op inside {6'h00, 6'h2B, 6'h04};
        exp_stall = HAZ && !r && m_out.valid && m_out.mr && (m_out.wreg != 5'd0) && ifv && !fl
                    && ((m_out.wreg == rs) || ((m_out.wreg == rt) && uses_rt));
        got_stall = bus.stall;
        nxt = '0;
        nxt.illegal = m_out.illegal || (ifv && !fl && !known);
        if (ifv && !fl && !exp_stall && known) begin
            nxt.valid = 1'b1;
            nxt.rd1   = ref_read(rs, we, wr, wd);
            nxt.rd2   = ref_read(rt, we, wr, wd);
            nxt.ext   = {{16{ins[15]}}, ins[15:0]};
            nxt.old   = pc;
            nxt.wreg  = rt;
            case (op)
                6'h00: begin nxt.alu_op = 2'b10; nxt.rw = 1'b1; nxt.wreg = ins[15:11]; end
                6'h23: begin nxt.alu_src = 1'b1; nxt.mr = 1'b1; nxt.m2r = 1'b1; nxt.rw = 1'b1; end
                6'h2B: begin nxt.alu_src = 1'b1; nxt.mw = 1'b1; end
                6'h04: begin nxt.alu_op = 2'b01; nxt.br = 1'b1; end
                default: begin nxt.alu_src = 1'b1; nxt.rw = 1'b1; end
            endcase
        end
        if (r) nxt = '0;
        @(posedge clk);
        m_out = nxt;
        if (r) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        end else if (we && wr != 5'd0) begin
            m_regs[wr] = wd;
        end
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        cycle(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        checks++;
        if (dut_out() !== out_t'('0)) $display("FAIL reset_out got=%h exp=0", dut_out());
        else passes++;
        checks++;
        if (bus.stall !== 1'b0) $display("FAIL reset_stall got=%b exp=0", bus.stall);
        else passes++;
    endtask

    task automatic test_addi();
        cycle(1'b0, 32'h20010005, 32'h0000_0004, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        checks++;
        if (dut_out() !== m_out) $display("FAIL addi_out got=%h exp=%h", dut_out(), m_out);
        else passes++;
        checks++;
        if ({bus.id_valid, bus.reg_write, bus.ALU_src, bus.write_reg, bus.extended_offset}
            !== {1'b1, 1'b1, 1'b1, 5'd1, 32'h5})
            $display("FAIL addi_fields got=%b%b%b %h %h exp=111 01 00000005",
                     bus.id_valid, bus.reg_write, bus.ALU_src, bus.write_reg, bus.extended_offset);
        else passes++;
    endtask

    task automatic test_bypass();
        cycle(1'b0, 32'h00421820, 32'h0000_0008, 1'b1, 1'b0, 1'b1, 5'd2, 32'hDEADBEEF);
        checks++;
        if ({bus.read_data_1, bus.read_data_2} !== {32'hDEADBEEF, 32'hDEADBEEF})
            $display("FAIL bypass_rd got=%h %h exp=deadbeef deadbeef", bus.read_data_1, bus.read_data_2);
        else passes++;
        cycle(1'b0, 32'h00001820, 32'h0000_000C, 1'b1, 1'b0, 1'b1, 5'd0, 32'h12345678);
        checks++;
        if ({bus.read_data_1, bus.read_data_2} !== 64'd0)
            $display("FAIL bypass_r0 got=%h %h exp=0 0", bus.read_data_1, bus.read_data_2);
        else passes++;
        checks++;
        if (dut_out() !== m_out) $display("FAIL bypass_out got=%h exp=%h", dut_out(), m_out);
        else passes++;
    endtask

    task automatic test_load_use();
        cycle(1'b0, 32'h8C240000, 32'h0000_0010, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        cycle(1'b0, 32'h00812820, 32'h0000_0014, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        checks++;
        if (got_stall !== HAZ) $display("FAIL loaduse_stall got=%b exp=%b", got_stall, HAZ);
        else passes++;
        checks++;
        if (bus.id_valid !== !HAZ) $display("FAIL loaduse_bubble got=%b exp=%b", bus.id_valid, !HAZ);
        else passes++;
        cycle(1'b0, 32'h00812820, 32'h0000_0014, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        checks++;
        if (got_stall !== 1'b0) $display("FAIL loaduse_stall2 got=%b exp=0", got_stall);
        else passes++;
        checks++;
        if ({bus.id_valid, bus.write_reg, bus.ALU_op} !== {1'b1, 5'd5, 2'b10})
            $display("FAIL loaduse_issue got=%b %h %b exp=1 05 10", bus.id_valid, bus.write_reg, bus.ALU_op);
        else passes++;
    endtask

    task automatic test_beq();
        cycle(1'b0, 32'h1022FFFC, 32'h0000_0100, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        checks++;
        if ({bus.ALU_op, bus.branch, bus.extended_offset, bus.old_address}
            !== {2'b01, 1'b1, 32'hFFFFFFFC, 32'h0000_0100})
            $display("FAIL beq_fields got=%b %b %h %h exp=01 1 fffffffc 00000100",
                     bus.ALU_op, bus.branch, bus.extended_offset, bus.old_address);
        else passes++;
        checks++;
        if (dut_out() !== m_out) $display("FAIL beq_out got=%h exp=%h", dut_out(), m_out);
        else passes++;
    endtask

    task automatic test_flush();
        cycle(1'b0, 32'h8C240000, 32'h0000_0200, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        cycle(1'b0, 32'h00812820, 32'h0000_0204, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
        checks++;
        if (got_stall !== 1'b0) $display("FAIL flush_stall got=%b exp=0", got_stall);
        else passes++;
        checks++;
        if (dut_out() !== m_out || bus.id_valid !== 1'b0)
            $display("FAIL flush_bubble got=%h exp=%h", dut_out(), m_out);
        else passes++;
    endtask

    task automatic test_reset_mid_stall();
        cycle(1'b0, 32'h8C240000, 32'h0000_0300, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        cycle(1'b1, 32'h00812820, 32'h0000_0304, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        checks++;
        if (dut_out() !== out_t'('0)) $display("FAIL midstall_reset got=%h exp=0", dut_out());
        else passes++;
        checks++;
        if (bus.stall !== 1'b0) $display("FAIL midstall_stall got=%b exp=0", bus.stall);
        else passes++;
        cycle(1'b0, 32'h00812820, 32'h0000_0304, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        checks++;
        if (dut_out() !== m_out || got_stall !== 1'b0)
            $display("FAIL midstall_issue got=%h stall=%b exp=%h stall=0", dut_out(), got_stall, m_out);
        else passes++;
    endtask

    task automatic test_illegal();
        cycle(1'b0, 32'hFC000000, 32'h0000_0400, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        checks++;
        if ({bus.illegal, bus.id_valid, bus.reg_write} !== 3'b100)
            $display("FAIL illegal_set got=%b%b%b exp=100", bus.illegal, bus.id_valid, bus.reg_write);
        else passes++;
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 32'h20010005, 32'h0000_0404, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        checks++;
        if (bus.illegal !== 1'b1) $display("FAIL illegal_sticky got=%b exp=1", bus.illegal);
        else passes++;
        cycle(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        checks++;
        if (bus.illegal !== 1'b0) $display("FAIL illegal_clear got=%b exp=0", bus.illegal);
        else passes++;
    endtask

    task automatic test_random();
        logic [31:0] ins;
        logic [5:0]  op;
        logic        hold;
        hold = 1'b0;
        ins  = 32'h0;
        for (int n = 0; n < 400; n++) begin
            if (!hold) begin
                case ($urandom_range(0, 15))
                    0, 1, 2, 3: op = 6'h00;
                    4, 5, 6, 7: op = 6'h23;
                    8, 9:       op = 6'h2B;
                    10, 11:     op = 6'h04;
                    12, 13, 14: op = 6'h08;
                    default:    op = 6'h3F;
                endcase
                ins = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                       5'($urandom_range(0, 7)), 11'($urandom)};
            end
            cycle(($urandom_range(0, 99) == 0), ins, $urandom, ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 9) == 0), 1'($urandom), 5'($urandom_range(0, 7)), $urandom);
            hold = exp_stall;
            checks++;
            if (got_stall !== exp_stall) $display("FAIL rand_stall n=%0d got=%b exp=%b", n, got_stall, exp_stall);
            else passes++;
            checks++;
            if (dut_out() !== m_out) $display("FAIL rand_out n=%0d got=%h exp=%h", n, dut_out(), m_out);
            else passes++;
        end
    endtask

    initial begin
        checks = 0;
        passes = 0;
        m_out  = '0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        rst = 1'b1;
        bus.instruction = 32'h0; bus.pc_plus4 = 32'h0; bus.if_valid = 1'b0; bus.flush = 1'b0;
        bus.wb_reg_write = 1'b0; bus.wb_write_reg = 5'd0; bus.wb_write_data = 32'h0;
        test_reset();
        test_addi();
        test_bypass();
        test_load_use();
        test_beq();
        test_flush();
        test_reset_mid_stall();
        test_illegal();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction-decode stage of the 5-stage MIPS pipeline. It sits between fetch and `execute`, and produces the operands, sign-extended offset, PC and ALU control fields that `execute` consumes. It owns the 32×32 register file, which the writeback stage writes through a dedicated port. It registers all outputs into the ID/EX pipeline register and detects load-use hazards, stalling fetch and inserting a bubble.

## Interface
Parameters:
- none; widths are fixed at 32-bit data and 5-bit register index.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `instruction`  in  32  instruction from IF/ID
- `pc_plus4`  in  32  PC+4 of `instruction`
- `if_valid`  in  1  `instruction` is real (0 = bubble)
- `flush`  in  1  branch taken; discard the instruction in decode
- `wb_reg_write`  in  1  writeback enable
- `wb_write_reg`  in  5  writeback destination
- `wb_write_data`  in  32  writeback data
- `stall`  out  1  combinational; fetch and IF/ID hold when 1
- `id_valid`  out  1  ID/EX contents are a real instruction
- `read_data_1`, `read_data_2`  out  32  rs/rt operands
- `extended_offset`  out  32  sign-extended imm[15:0]
- `old_address`  out  32  registered `pc_plus4`
- `ALU_op`  out  2  00 add, 01 sub, 10 funct-decoded
- `ALU_src`  out  1  0 = `read_data_2`, 1 = `extended_offset`
- `reg_write`, `mem_read`, `mem_write`, `mem_to_reg`, `branch`  out  1 each  downstream control
- `write_reg`  out  5  destination index (rd for R-type, rt otherwise)
- `illegal`  out  1  sticky; unknown opcode seen

## Operation
- Decode by opcode [31:26]:
  - 000000 R-type: `ALU_op`=10, `ALU_src`=0, `reg_write`=1, dst=rd.
  - 100011 lw: `ALU_op`=00, `ALU_src`=1, `mem_read`=1, `mem_to_reg`=1, `reg_write`=1, dst=rt.
  - 101011 sw: `ALU_op`=00, `ALU_src`=1, `mem_write`=1.
  - 000100 beq: `ALU_op`=01, `ALU_src`=0, `branch`=1.
  - 001000 addi: `ALU_op`=00, `ALU_src`=1, `reg_write`=1, dst=rt.
  - Any other opcode: bubble, and set `illegal` (cleared only by `rst`).
- Register file:
  - Reg 0 reads 0; writes to it are ignored.
  - Write occurs on `clk` when `wb_reg_write`=1.
  - Read bypass: if `wb_reg_write` and `wb_write_reg`==source index≠0, the read returns `wb_write_data` in the same cycle.
- Sign extension: `extended_offset` = {{16{imm[15]}}, imm[15:0]}; computed for every instruction, including R-type, where it carries funct.
- Load-use hazard:
  - `stall`=1 when `id_valid`∧`mem_read`∧`write_reg`≠0∧`if_valid`∧(`write_reg`==rs ∨ (`write_reg`==rt ∧ opcode∈{R-type, sw, beq})).
- Bubble: `id_valid`=0 and all control outputs (`reg_write`..`branch`, `ALU_op`, `ALU_src`) 0; data fields are don't-care but driven 0.
- Priority per edge: `rst` > `flush` > `stall` > normal.
  - `flush` ⇒ bubble, and `stall` forced 0.
  - `stall` ⇒ bubble; the instruction is re-decoded next cycle.
  - `if_valid`=0 ⇒ bubble.

## Timing
- Reset: every output 0, all 32 registers 0, `illegal` 0, `stall` 0.
- Latency: an instruction presented at edge N appears on the ID/EX outputs after edge N.
- `stall` lasts exactly one cycle per load-use pair, because the following bubble clears `mem_read`.
- WB write and decode read of the same register in one cycle: the new value is used (bypass).
- Reset asserted mid-stall: the next cycle has `stall`=0 and all state cleared.

## Configuration
- `DECODE_HAZARD_EN` defined: load-use detection and bubble insertion as above.
- Not defined: `stall` tied 0 and no hazard bubbles; the compiler guarantees load-use spacing.

## Test plan
- Reset, then `addi $1,$0,5` (0x20010005) -> next cycle: `reg_write`=1, `write_reg`=1, `ALU_src`=1, `extended_offset`=0x00000005, `id_valid`=1.
- WB writes $2=0xDEADBEEF while `add $3,$2,$2` is in decode -> `read_data_1`=`read_data_2`=0xDEADBEEF; a WB write to $0 still reads 0.
- `lw $4,0($1)` followed by `add $5,$4,$1` -> `stall`=1 for one cycle, a bubble enters ID/EX, and `add` issues the cycle after. Without `DECODE_HAZARD_EN`, there is no stall.
- `beq` with imm 0xFFFC -> `ALU_op`=01, `branch`=1, `extended_offset`=0xFFFFFFFC, `old_address`=`pc_plus4`.
- `flush`=1 concurrent with a load-use condition -> bubble, `stall`=0.
- Opcode 0x3F -> bubble, `illegal`=1, which stays 1 until `rst`.
